packet_router: RTL

Downstream consumer of the packet generator stage. Samples each 13-bit packet on `packet_valid` and optionally checks its parity. Buffers accepted packets in a small FIFO and forwards each payload to one of four destination ports over a valid/ready handshake. The generator has no backpressure, so this block absorbs bursts and drops and counts packets it cannot hold.

---
 rtl/packet_router.sv | 120 ++++++++++++
 1 files changed

// File: rtl/packet_router.sv
// Packet sink: parity screen, small in-order FIFO, one-hot routing to four ports.
// Optional feature macro: PKT_PARITY_CHECK_EN (even-parity screening and err_count).
module packet_router #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          packet_valid,
  input  logic [12:0]                   packet,
  output logic [3:0]                    out_valid,
  input  logic [3:0]                    out_ready,
  output logic [9:0]                    out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              drop_count,
  output logic [CNT_W-1:0]              err_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

  // Entries hold {dest[1:0], payload[9:0]}; the parity bit is not needed past the input.
  logic [11:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [11:0] head;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        parity_err;

`ifdef PKT_PARITY_CHECK_EN
  assign parity_err = ^packet;
`else
  logic unused_parity_bit;
  assign parity_err        = 1'b0;
  assign unused_parity_bit = packet[0];
`endif

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_OCC);

  // NOTE: combinational blocks use blocking '=' with every output defaulted first,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    out_valid = 4'b0000;
    out_data  = 10'd0;
    if (!empty) begin
      out_valid = 4'b0001 << head[11:10];
      out_data  = head[9:0];
    end
  end

  // Only the head's own port can pop it; readiness elsewhere is irrelevant.
  assign pop  = |(out_valid & out_ready);
  assign push = packet_valid && !parity_err && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (packet_valid && !parity_err && full && !pop && (drop_q != '1))
      drop_d = drop_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy gates every read, so
  // stale contents are never visible and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= packet[12:1];
  end

`ifdef PKT_PARITY_CHECK_EN
  logic [CNT_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (packet_valid && parity_err && (err_q != '1)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

  assign fifo_count = count_q;
  assign drop_count = drop_q;

endmodule
